// File: rtl/weight_buffer_loader_pkg.sv
// ---------------------------------------------------------------------------
// genesys_wbuf_pkg
// Shared types and constants for the weight buffer fill engine.
//   - wbufState_e : loader FSM states (IDLE, LOAD, DONE)
//   - default widths, beat-to-word RATIO and SLICE_IDX_W for the default build
//   - sliceIdxWidth() : width of a slice index for any beat/word ratio
// Optional feature macro used by the loader: WEIGHT_BUFFER_LOADER_PERF_EN
// ---------------------------------------------------------------------------
package genesys_wbuf_pkg;

    localparam int DDR_BANDWIDTH_DEF    = 512;
    localparam int WRITE_WIDTH_DEF      = 128;
    localparam int WRITE_ADDR_WIDTH_DEF = 8;
    localparam int LEN_WIDTH_DEF        = 16;

    // A ratio of 1 still needs a one-bit index so the splitter never
    // declares a zero-width register.
    function automatic int sliceIdxWidth(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    localparam int RATIO       = DDR_BANDWIDTH_DEF / WRITE_WIDTH_DEF;
    localparam int SLICE_IDX_W = sliceIdxWidth(RATIO);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wbufState_e;

endpackage

// File: rtl/weight_buffer_loader_if.sv
// ---------------------------------------------------------------------------
// weight_buffer_loader_if
// Bundles the command, DDR beat and buffer write signals of the loader.
//   master : command/beat source side (drives cmd_*, ddr_data_valid, ddr_data)
//   slave  : the loader itself (drives ready, write port, busy, done)
// Signals: cmd_valid/cmd_ready/cmd_base_addr/cmd_num_words,
//          ddr_data_valid/ddr_data_ready/ddr_data,
//          bs_write_req/bs_write_addr/bs_write_data, busy, done,
//          perf_stall_cycles (only when WEIGHT_BUFFER_LOADER_PERF_EN is defined)
// ---------------------------------------------------------------------------
interface weight_buffer_loader_if
    import genesys_wbuf_pkg::*;
#(
    parameter int DDR_BANDWIDTH    = DDR_BANDWIDTH_DEF,
    parameter int WRITE_WIDTH      = WRITE_WIDTH_DEF,
    parameter int WRITE_ADDR_WIDTH = WRITE_ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH        = LEN_WIDTH_DEF
);

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [WRITE_ADDR_WIDTH-1:0] cmd_base_addr;
    logic [LEN_WIDTH-1:0]        cmd_num_words;

    logic                        ddr_data_valid;
    logic                        ddr_data_ready;
    logic [DDR_BANDWIDTH-1:0]    ddr_data;

    logic                        bs_write_req;
    logic [WRITE_ADDR_WIDTH-1:0] bs_write_addr;
    logic [WRITE_WIDTH-1:0]      bs_write_data;

    logic                        busy;
    logic                        done;

`ifdef WEIGHT_BUFFER_LOADER_PERF_EN
    logic [31:0]                 perf_stall_cycles;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_words,
        output ddr_data_valid, ddr_data,
        input  cmd_ready, ddr_data_ready,
        input  bs_write_req, bs_write_addr, bs_write_data,
        input  busy, done, perf_stall_cycles
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_words,
        input  ddr_data_valid, ddr_data,
        output cmd_ready, ddr_data_ready,
        output bs_write_req, bs_write_addr, bs_write_data,
        output busy, done, perf_stall_cycles
    );
`else
    modport master (
        output cmd_valid, cmd_base_addr, cmd_num_words,
        output ddr_data_valid, ddr_data,
        input  cmd_ready, ddr_data_ready,
        input  bs_write_req, bs_write_addr, bs_write_data,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_num_words,
        input  ddr_data_valid, ddr_data,
        output cmd_ready, ddr_data_ready,
        output bs_write_req, bs_write_addr, bs_write_data,
        output busy, done
    );
`endif

endinterface

// File: rtl/weight_buffer_loader_splitter.sv
// ---------------------------------------------------------------------------
// wbuf_beat_splitter
// Holds one DDR beat and presents it one WRITE_WIDTH slice per cycle,
// slice 0 (least significant bits) first.
//   clk, reset      : clock, asynchronous active-high reset
//   loadBeat_i      : capture beat_i into the hold this cycle
//   beat_i          : incoming DDR beat
//   lastWord_i      : the slice presented now is the final word of the command
//   holdValid_o     : hold contains a slice to write (write request)
//   sliceData_o     : currently selected slice
//   holdRelease_o   : the hold empties after this cycle's write
// ---------------------------------------------------------------------------
module wbuf_beat_splitter
    import genesys_wbuf_pkg::*;
#(
    parameter int DDR_BANDWIDTH = DDR_BANDWIDTH_DEF,
    parameter int WRITE_WIDTH   = WRITE_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     loadBeat_i,
    input  logic [DDR_BANDWIDTH-1:0] beat_i,
    input  logic                     lastWord_i,
    output logic                     holdValid_o,
    output logic [WRITE_WIDTH-1:0]   sliceData_o,
    output logic                     holdRelease_o
);

    localparam int BEAT_RATIO = DDR_BANDWIDTH / WRITE_WIDTH;
    localparam int IDX_W      = sliceIdxWidth(BEAT_RATIO);

    logic [DDR_BANDWIDTH-1:0] holdData_q, holdData_d;
    logic                     holdValid_q, holdValid_d;
    logic [IDX_W-1:0]         sliceIdx_q, sliceIdx_d;
    logic                     lastSlice;
    logic [WRITE_WIDTH-1:0]   slices [BEAT_RATIO];

    for (genvar g = 0; g < BEAT_RATIO; g++) begin : gSlice
        assign slices[g] = holdData_q[g*WRITE_WIDTH +: WRITE_WIDTH];
    end

    assign lastSlice     = (sliceIdx_q == IDX_W'(BEAT_RATIO - 1));
    // A partial final beat empties early; its remaining slices are dropped.
    assign holdRelease_o = holdValid_q && (lastSlice || lastWord_i);
    assign holdValid_o   = holdValid_q;
    assign sliceData_o   = slices[sliceIdx_q];

    // A new beat always restarts at slice 0. The index wraps on the last
    // slice so it never points outside the slice table.
    always_comb begin
        holdData_d  = holdData_q;
        holdValid_d = holdValid_q;
        sliceIdx_d  = sliceIdx_q;
        if (loadBeat_i) begin
            holdData_d  = beat_i;
            holdValid_d = 1'b1;
            sliceIdx_d  = '0;
        end else if (holdValid_q) begin
            sliceIdx_d = lastSlice ? '0 : sliceIdx_q + IDX_W'(1);
            if (holdRelease_o) begin
                holdValid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            holdData_q  <= '0;
            holdValid_q <= 1'b0;
            sliceIdx_q  <= '0;
        end else begin
            holdData_q  <= holdData_d;
            holdValid_q <= holdValid_d;
            sliceIdx_q  <= sliceIdx_d;
        end
    end

endmodule

// File: rtl/weight_buffer_loader.sv
// ---------------------------------------------------------------------------
// weight_buffer_loader
// Fill engine in front of the weight buffer. Takes one load command (base
// address, word count), accepts DDR beats and writes them to the buffer one
// WRITE_WIDTH word per cycle, without bubbles while DDR keeps up.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : weight_buffer_loader_if.slave (command, DDR beat, buffer
//                write port, busy, done, optional perf_stall_cycles)
// Optional feature: define WEIGHT_BUFFER_LOADER_PERF_EN to add a saturating
// 32-bit count of LOAD cycles spent waiting for DDR data.
// ---------------------------------------------------------------------------
module weight_buffer_loader
    import genesys_wbuf_pkg::*;
#(
    parameter int DDR_BANDWIDTH    = DDR_BANDWIDTH_DEF,
    parameter int WRITE_WIDTH      = WRITE_WIDTH_DEF,
    parameter int WRITE_ADDR_WIDTH = WRITE_ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH        = LEN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    weight_buffer_loader_if.slave bus
);

    localparam int BEAT_RATIO = DDR_BANDWIDTH / WRITE_WIDTH;
    localparam int RATIO_LOG2 = $clog2(BEAT_RATIO);

    wbufState_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]        wordsLeft_q, wordsLeft_d;
    logic [LEN_WIDTH-1:0]        beatsLeft_q, beatsLeft_d;
    logic [WRITE_ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;

    logic                        cmdAccept;
    logic                        beatAccept;
    logic                        ddrReady;
    logic                        holdValid;
    logic                        holdRelease;
    logic                        lastWord;
    logic                        lastWrite;
    logic [WRITE_WIDTH-1:0]      sliceData;
    logic [LEN_WIDTH-1:0]        beatsForCmd;

    assign cmdAccept  = (state_q == IDLE) && bus.cmd_valid;
    assign lastWord   = (wordsLeft_q == LEN_WIDTH'(1));
    assign lastWrite  = holdValid && lastWord;
    // Taking the next beat in the same cycle as the hold's last write keeps
    // the write port busy on every cycle of back-to-back beats.
    assign ddrReady   = (state_q == LOAD) && (beatsLeft_q != '0)
                        && (!holdValid || holdRelease);
    assign beatAccept = ddrReady && bus.ddr_data_valid;

    // ceil(num_words / RATIO), computed one bit wider so the rounding add
    // cannot overflow for the largest word count.
    assign beatsForCmd = LEN_WIDTH'(({1'b0, bus.cmd_num_words}
                                     + (LEN_WIDTH+1)'(BEAT_RATIO - 1)) >> RATIO_LOG2);

    wbuf_beat_splitter #(
        .DDR_BANDWIDTH (DDR_BANDWIDTH),
        .WRITE_WIDTH   (WRITE_WIDTH)
    ) uSplitter (
        .clk           (clk),
        .reset         (reset),
        .loadBeat_i    (beatAccept),
        .beat_i        (bus.ddr_data),
        .lastWord_i    (lastWord),
        .holdValid_o   (holdValid),
        .sliceData_o   (sliceData),
        .holdRelease_o (holdRelease)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A zero-length command skips LOAD entirely so no beat is ever taken.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmdAccept) begin
                    state_d = (bus.cmd_num_words == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (lastWrite) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters only move on a real write or beat accept, so DDR starvation
    // simply freezes them.
    always_comb begin
        wordsLeft_d = wordsLeft_q;
        beatsLeft_d = beatsLeft_q;
        wrAddr_d    = wrAddr_q;
        if (cmdAccept) begin
            wordsLeft_d = bus.cmd_num_words;
            beatsLeft_d = beatsForCmd;
            wrAddr_d    = bus.cmd_base_addr;
        end else begin
            if (holdValid) begin
                wordsLeft_d = wordsLeft_q - LEN_WIDTH'(1);
                wrAddr_d    = wrAddr_q + WRITE_ADDR_WIDTH'(1);
            end
            if (beatAccept) begin
                beatsLeft_d = beatsLeft_q - LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wordsLeft_q <= '0;
            beatsLeft_q <= '0;
            wrAddr_q    <= '0;
        end else begin
            wordsLeft_q <= wordsLeft_d;
            beatsLeft_q <= beatsLeft_d;
            wrAddr_q    <= wrAddr_d;
        end
    end

    // The write port comes only from registered state, never from ddr_data.
    always_comb begin
        bus.cmd_ready      = (state_q == IDLE);
        bus.ddr_data_ready = ddrReady;
        bus.bs_write_req   = holdValid;
        bus.bs_write_addr  = wrAddr_q;
        bus.bs_write_data  = sliceData;
        bus.busy           = (state_q != IDLE);
        bus.done           = (state_q == DONE);
    end

`ifdef WEIGHT_BUFFER_LOADER_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d;

    // Counts LOAD cycles that still expect a beat but have nothing to write.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (cmdAccept) begin
            stallCnt_d = '0;
        end else if ((state_q == LOAD) && !holdValid && (beatsLeft_q != '0)
                     && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign bus.perf_stall_cycles = stallCnt_q;
`else
    // No stall counter in this build.
`endif

endmodule
